// File: rtl/ctx_seq_pkg.sv
// Shared types and constants for the context arithmetic sequencer.
package ctx_seq_pkg;

  localparam int unsigned DEF_NBITS = 8;

  // Quotient substituted when the divisor is zero.
  localparam logic [DEF_NBITS-1:0] DIV0_QUOT = '1;

  typedef enum logic [2:0] {
    IDLE,
    SUB,
    DIV,
    MUL,
    HOLD
  } state_e;

endpackage

// File: rtl/ctx_restoring_div.sv
// Iterative restoring divider: one quotient bit per cycle, NBITS cycles per divide.
module ctx_restoring_div #(
  parameter int unsigned NBITS = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [NBITS-1:0] DIVIDEND,
  input  logic [NBITS-1:0] DIVISOR,
  output logic             BUSY,
  output logic             DONE,
  output logic [NBITS-1:0] QUOT
);

  localparam int CW = $clog2(NBITS + 1);

  logic [NBITS-1:0] rem_q, rem_d;
  logic [NBITS-1:0] quot_q, quot_d;
  logic [NBITS-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic [NBITS:0]   shifted;
  logic [NBITS:0]   trial;
  logic             bit_ok;

  always_comb begin
    shifted = {rem_q, quot_q[NBITS-1]};
    trial   = shifted - {1'b0, dvs_q};
    bit_ok  = ~trial[NBITS];
    rem_d   = bit_ok ? trial[NBITS-1:0] : shifted[NBITS-1:0];
    quot_d  = {quot_q[NBITS-2:0], bit_ok};
  end

  // QUOT is the combinational final step so the caller can use it on the DONE edge.
  assign BUSY = (cnt_q != '0);
  assign DONE = (cnt_q == CW'(1));
  assign QUOT = quot_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
    end else if (START) begin
      rem_q  <= '0;
      quot_q <= DIVIDEND;
      dvs_q  <= DIVISOR;
      cnt_q  <= CW'(NBITS);
    end else if (BUSY) begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/ctx_op_sequencer.sv
// Sequencer computing c = A-B, d += A/B and XOUT = c + A*B per operand pair.
//   state | meaning
//   IDLE  | ready for operands
//   SUB   | register c = A - B, launch divider
//   DIV   | wait for quotient (or substitute all-ones), accumulate
//   MUL   | register XOUT = c + A*B
//   HOLD  | present result until consumer accepts
module ctx_op_sequencer
  import ctx_seq_pkg::*;
#(
  parameter int unsigned NBITS = DEF_NBITS
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [NBITS-1:0] A,
  input  logic [NBITS-1:0] B,
  input  logic             CLR_ACC,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [NBITS-1:0] XOUT,
  output logic [NBITS-1:0] DOUT,
  output logic             DIV0
);

  localparam logic [NBITS-1:0] QUOT_ALL1 = '1;

  state_e             state_q, state_d;
  logic [NBITS-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
  logic [NBITS-1:0]   acc_q, acc_d, xout_q, xout_d;
  logic               div0_q, div0_d, out_valid_q, out_valid_d;
  logic               acc_en;
  logic [NBITS-1:0]   q_sel;
  logic [2*NBITS-1:0] prod;
  logic               div_start, div_busy, div_done;
  logic [NBITS-1:0]   div_quot;

  ctx_restoring_div #(.NBITS(NBITS)) u_div (
    .CLK      (CLK),
    .RST      (RST),
    .START    (div_start),
    .DIVIDEND (a_q),
    .DIVISOR  (b_q),
    .BUSY     (div_busy),
    .DONE     (div_done),
    .QUOT     (div_quot)
  );

  assign prod      = a_q * b_q;
  assign div_start = (state_q == SUB) && (b_q != '0) && !div_busy;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    xout_d      = xout_q;
    div0_d      = div0_q;
    out_valid_d = out_valid_q;
    acc_en      = 1'b0;
    q_sel       = '0;
    case (state_q)
      IDLE: if (IN_VALID) begin
        a_d     = A;
        b_d     = B;
        state_d = SUB;
      end
      SUB: begin
        c_d     = a_q - b_q;
        state_d = DIV;
      end
      DIV: begin
        div0_d = (b_q == '0);
        if (b_q == '0) begin
          acc_en  = 1'b1;
          q_sel   = QUOT_ALL1;
          state_d = MUL;
        end else if (div_done) begin
          acc_en  = 1'b1;
          q_sel   = div_quot;
          state_d = MUL;
        end
      end
      MUL: begin
        xout_d      = c_q + prod[NBITS-1:0];
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: if (OUT_READY) begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Clear beats a coincident accumulate; the quotient is dropped.
    if (CLR_ACC)     acc_d = '0;
    else if (acc_en) acc_d = acc_q + q_sel;
    else             acc_d = acc_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      acc_q       <= '0;
      xout_q      <= '0;
      div0_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      acc_q       <= acc_d;
      xout_q      <= xout_d;
      div0_q      <= div0_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign IN_READY  = (state_q == IDLE);
  assign OUT_VALID = out_valid_q;
  assign XOUT      = xout_q;
  assign DOUT      = acc_q;
  assign DIV0      = div0_q;

endmodule

// File: tb/tb_ctx_op_sequencer.sv
// Scoreboard bench for ctx_op_sequencer: expected results queued at issue, checked at OUT_VALID.
module tb_ctx_op_sequencer;

  localparam int NB   = 8;
  localparam int MASK = (1 << NB) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [NB-1:0] A = '0;
  logic [NB-1:0] B = '0;
  logic          CLR_ACC = 1'b0;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
  logic [NB-1:0] XOUT;
  logic [NB-1:0] DOUT;
  logic          DIV0;

  ctx_op_sequencer #(.NBITS(NB)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .CLR_ACC   (CLR_ACC),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .XOUT      (XOUT),
    .DOUT      (DOUT),
    .DIV0      (DIV0)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int x;
    int d;
    int dv;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   acc_m;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; CLR_ACC = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    acc_m = 0;
    sb.delete();
  endtask

  // clr_edge: edge index after acceptance on which CLR_ACC is asserted (0 = never).
  task automatic run_op(input int a, input int b, input int clr_edge, input int bp_cycles);
    int   k;
    int   q;
    exp_t e;
    logic [NB-1:0] x_hold, d_hold;
    logic          v_hold;
    k = 0;
    while (!IN_READY && k < 50) begin @(posedge CLK); #1; k++; end
    chk("in_ready_idle", IN_READY, 1);
    q     = (b == 0) ? MASK : a / b;
    acc_m = (clr_edge != 0) ? 0 : (acc_m + q) & MASK;
    e.x   = ((a - b) + a * b) & MASK;
    e.d   = acc_m;
    e.dv  = (b == 0) ? 1 : 0;
    e.lat = (b == 0) ? 4 : NB + 3;
    sb.push_back(e);
    A = a[NB-1:0]; B = b[NB-1:0]; IN_VALID = 1'b1;
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
    k = 0;
    while (!OUT_VALID && k < 60) begin
      if (k + 1 == clr_edge) CLR_ACC = 1'b1;
      @(posedge CLK);
      #1 CLR_ACC = 1'b0;
      k++;
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("latency_edges", k + 1, e.lat);
      chk("xout", XOUT, e.x);
      chk("dout", DOUT, e.d);
      chk("div0", DIV0, e.dv);
    end
    x_hold = XOUT; d_hold = DOUT; v_hold = DIV0;
    for (int i = 0; i < bp_cycles; i++) begin
      IN_VALID = 1'b1;
      A = NB'($urandom); B = NB'($urandom);
      @(posedge CLK);
      #1;
      chk("bp_out_valid", OUT_VALID, 1);
      chk("bp_in_ready", IN_READY, 0);
      chk("bp_xout", XOUT, x_hold);
      chk("bp_dout", DOUT, d_hold);
      chk("bp_div0", DIV0, v_hold);
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    @(posedge CLK);
    #1 OUT_READY = 1'b0;
    chk("hs_out_valid", OUT_VALID, 0);
    chk("hs_in_ready", IN_READY, 1);
    if (bp_cycles > 0) begin
      @(posedge CLK);
      #1;
      chk("no_extra_capture", IN_READY, 1);
      chk("no_extra_valid", OUT_VALID, 0);
    end
  endtask

  initial begin
    int seen;

    do_reset();
    chk("rst_in_ready", IN_READY, 1);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_xout", XOUT, 0);
    chk("rst_dout", DOUT, 0);
    chk("rst_div0", DIV0, 0);

    run_op(20, 3, 0, 0);
    run_op(100, 7, 0, 0);

    do_reset();
    run_op(3, 5, 0, 0);

    do_reset();
    run_op(9, 0, 0, 0);
    run_op(8, 4, 0, 5);

    // Reset during the fourth DIV cycle abandons the operation.
    do_reset();
    run_op(20, 3, 0, 0);
    A = 8'd50; B = 8'd5; IN_VALID = 1'b1;
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
    repeat (4) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    acc_m = 0;
    chk("midrst_in_ready", IN_READY, 1);
    chk("midrst_dout", DOUT, 0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge CLK);
      #1;
      if (OUT_VALID) seen++;
    end
    chk("midrst_no_valid", seen, 0);
    run_op(20, 3, 0, 0);

    // Clear coincident with the accumulate edge; accumulator holds 6 beforehand.
    run_op(20, 3, NB + 1, 0);
    run_op(40, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
